// File: rtl/weight_fetch_scheduler.sv
// Weight fetch scheduler: streams MUL_SIZE rows per tile from weight memory under FIFO
// back-pressure and delays each read strobe by MEM_LAT cycles to form the FIFO push.
module weight_fetch_scheduler #(
    parameter int unsigned MUL_SIZE   = 32,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned MEM_LAT    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [7:0]        u_dim_i,
    input  logic [7:0]        iter_dim_i,
    input  logic              fifo_pop_i,
    output logic              busy_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              fifo_push_o,
    output logic              tile_done_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned      LOG2_MUL = $clog2(MUL_SIZE);
    localparam int unsigned      OCC_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0]      ROW_MASK = 16'(MUL_SIZE - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [15:0]         tiles_q, tiles_d;
    logic [15:0]         row_cnt_q, row_cnt_d;
    logic [15:0]         tile_cnt_q, tile_cnt_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                tile_done_q, tile_done_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [MEM_LAT-1:0]  lat_q;
    logic [MEM_LAT:0]    pipe;

    logic [7:0]          u_tiles, i_tiles;
    logic [15:0]         tiles_new;
    logic                issue, pop_ok, tile_end, last_row;

    assign u_tiles   = u_dim_i >> LOG2_MUL;
    assign i_tiles   = iter_dim_i >> LOG2_MUL;
    assign tiles_new = 16'(u_tiles) * 16'(i_tiles);

    // Read strobe followed by the latency line; the top bit is the push.
    assign pipe = {lat_q, rd_en_q};

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        tiles_d     = tiles_q;
        row_cnt_d   = row_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        tile_done_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        tile_end = (row_cnt_q & ROW_MASK) == ROW_MASK;
        last_row = tile_end && (tile_cnt_q == tiles_q - 16'd1);
        issue    = (state_q == StFetch) && (occ_q < OCC_FULL);
        pop_ok   = fifo_pop_i && (occ_q != '0);

        occ_d = occ_q;
        if (issue && !pop_ok) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!issue && pop_ok) begin
            occ_d = occ_q - OCC_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (tiles_new == 16'd0) begin
                        err_d = 1'b1;
                    end else begin
                        base_d     = base_addr_i;
                        tiles_d    = tiles_new;
                        row_cnt_d  = '0;
                        tile_cnt_d = '0;
                        state_d    = StFetch;
                    end
                end
            end
            StFetch: begin
                err_d = start_i;
                if (issue) begin
                    rd_en_d     = 1'b1;
                    addr_d      = base_q + ADDR_W'(row_cnt_q);
                    tile_done_d = tile_end;
                    row_cnt_d   = row_cnt_q + 16'd1;
                    if (tile_end) begin
                        tile_cnt_d = tile_cnt_q + 16'd1;
                    end
                    if (last_row) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                err_d = start_i;
                // Only the final push may still be visible; everything before it is empty.
                if (pipe[MEM_LAT-1:0] == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            base_q      <= '0;
            tiles_q     <= '0;
            row_cnt_q   <= '0;
            tile_cnt_q  <= '0;
            occ_q       <= '0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            tile_done_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            tiles_q     <= tiles_d;
            row_cnt_q   <= row_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            occ_q       <= occ_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            tile_done_q <= tile_done_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lat_q       <= pipe[MEM_LAT-1:0];
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign mem_rd_en_o = rd_en_q;
    assign mem_addr_o  = addr_q;
    assign fifo_push_o = lat_q[MEM_LAT-1];
    assign tile_done_o = tile_done_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// Bench for weight_fetch_scheduler: command table plus hand-written back-pressure,
// overlap and reset sequences, checked against an address/push scoreboard.
module tb_weight_fetch_scheduler;

    localparam int MEM_LAT = 2;
    localparam int MUL     = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] base_addr_i = '0;
    logic [7:0]  u_dim_i = '0;
    logic [7:0]  iter_dim_i = '0;
    logic        fifo_pop_i = 1'b0;
    logic        busy_o, mem_rd_en_o, fifo_push_o, tile_done_o, done_o, err_o;
    logic [15:0] mem_addr_o;

    weight_fetch_scheduler dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .u_dim_i     (u_dim_i),
        .iter_dim_i  (iter_dim_i),
        .fifo_pop_i  (fifo_pop_i),
        .busy_o      (busy_o),
        .mem_rd_en_o (mem_rd_en_o),
        .mem_addr_o  (mem_addr_o),
        .fifo_push_o (fifo_push_o),
        .tile_done_o (tile_done_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        tdone;
    } rd_exp_t;

    typedef struct {
        logic [15:0] base;
        logic [7:0]  u;
        logic [7:0]  it;
        logic        exp_err;
        int          exp_rows;
    } vec_t;

    rd_exp_t rd_q[$];
    int      push_q[$];
    int      n_tests = 0;
    int      n_fail = 0;
    int      cyc = 0;
    int      n_reads = 0;
    int      n_done = 0;
    int      last_push = -10;
    int      rd_first = -1;
    int      rd_last = -1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_cmd(input logic [15:0] base, input int rows);
        for (int r = 0; r < rows; r++) begin
            rd_q.push_back('{addr: 16'(int'(base) + r), tdone: ((r % MUL) == MUL - 1)});
        end
    endtask

    task automatic issue_start(input logic [15:0] b, input logic [7:0] u, input logic [7:0] it);
        start_i     = 1'b1;
        base_addr_i = b;
        u_dim_i     = u;
        iter_dim_i  = it;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done_o && k < budget) begin
            tick(1);
            k++;
        end
        check("done_seen", int'(done_o), 1);
    endtask

    task automatic wait_reads(input int target, input int budget);
        int k = 0;
        while (n_reads < target && k < budget) begin
            tick(1);
            k++;
        end
        check("reads_reached", n_reads, target);
    endtask

    function automatic int outs();
        return int'({busy_o, mem_rd_en_o, mem_addr_o, fifo_push_o, tile_done_o, done_o, err_o});
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    initial begin
        forever begin
            logic exp_push;
            @(negedge clk);
            cyc++;
            if (rst) begin
                rd_q.delete();
                push_q.delete();
                continue;
            end
            if (mem_rd_en_o) begin
                n_reads++;
                if (rd_first < 0) rd_first = cyc;
                rd_last = cyc;
                if (rd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: got addr 0x%0h expected no read", mem_addr_o);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    check("rd_addr", int'(mem_addr_o), int'(e.addr));
                    check("rd_tile_done", int'(tile_done_o), int'(e.tdone));
                end
                push_q.push_back(cyc + MEM_LAT);
            end else if (tile_done_o) begin
                check("stray_tile_done", int'(tile_done_o), 0);
            end
            exp_push = (push_q.size() > 0) && (push_q[0] == cyc);
            if (exp_push) push_q.delete(0);
            if (exp_push || fifo_push_o) begin
                check("push_align", int'(fifo_push_o), int'(exp_push));
                if (fifo_push_o) last_push = cyc;
            end
            if (done_o) begin
                n_done++;
                check("done_timing", cyc, last_push + 1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   r0;

        vecs[0] = '{16'h0100, 8'd32,  8'd32, 1'b0, 32};
        vecs[1] = '{16'h1000, 8'd16,  8'd64, 1'b1, 0};
        vecs[2] = '{16'hFFF0, 8'd32,  8'd32, 1'b0, 32};
        vecs[3] = '{16'h0400, 8'd96,  8'd32, 1'b0, 96};
        vecs[4] = '{16'h0500, 8'd255, 8'd0,  1'b1, 0};
        vecs[5] = '{16'h0600, 8'd64,  8'd63, 1'b0, 64};

        // Reset and idle quiet period.
        #2;
        check("reset_outs", outs(), 0);
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("idle_outs", outs(), 0);
        end

        // Single tile with steady pops: consecutive reads, done after last push.
        fifo_pop_i = 1'b1;
        r0 = n_reads;
        rd_first = -1;
        load_cmd(16'h0100, 32);
        issue_start(16'h0100, 8'd32, 8'd32);
        check("busy_after_start", int'(busy_o), 1);
        wait_done(200);
        check("busy_in_done", int'(busy_o), 0);
        check("reads_1tile", n_reads - r0, 32);
        check("reads_consecutive", rd_last - rd_first, 31);
        tick(2);

        // Command table.
        for (int v = 0; v < 6; v++) begin
            r0 = n_reads;
            if (!vecs[v].exp_err) load_cmd(vecs[v].base, vecs[v].exp_rows);
            issue_start(vecs[v].base, vecs[v].u, vecs[v].it);
            check("tbl_err", int'(err_o), int'(vecs[v].exp_err));
            check("tbl_busy", int'(busy_o), int'(!vecs[v].exp_err));
            if (vecs[v].exp_err) begin
                tick(1);
                check("tbl_err_pulse", int'(err_o), 0);
                tick(5);
                check("tbl_no_reads", n_reads - r0, 0);
                check("tbl_busy_idle", int'(busy_o), 0);
            end else begin
                wait_done(400);
                check("tbl_reads", n_reads - r0, vecs[v].exp_rows);
                check("tbl_queue_empty", rd_q.size(), 0);
            end
            tick(2);
        end

        // Start while fetching is rejected; start in done cycle is accepted.
        r0 = n_reads;
        load_cmd(16'h0200, 64);
        issue_start(16'h0200, 8'd64, 8'd32);
        wait_reads(r0 + 10, 100);
        issue_start(16'h9999, 8'd32, 8'd32);
        check("busy_start_err", int'(err_o), 1);
        tick(1);
        check("busy_start_err_pulse", int'(err_o), 0);
        wait_done(300);
        load_cmd(16'h0700, 32);
        issue_start(16'h0700, 8'd32, 8'd32);
        check("restart_err", int'(err_o), 0);
        check("restart_busy", int'(busy_o), 1);
        wait_done(200);
        check("overlap_reads", n_reads - r0, 96);
        tick(2);

        // Full back-pressure: 64 reads, stall, one pop releases one read.
        fifo_pop_i = 1'b0;
        r0 = n_reads;
        load_cmd(16'h0000, 128);
        issue_start(16'h0000, 8'd64, 8'd64);
        wait_reads(r0 + 64, 200);
        tick(20);
        check("stall_reads", n_reads - r0, 64);
        check("stall_busy", int'(busy_o), 1);
        fifo_pop_i = 1'b1;
        tick(1);
        fifo_pop_i = 1'b0;
        tick(10);
        check("one_pop_one_read", n_reads - r0, 65);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);

        // Reset mid-command cancels in-flight reads; occupancy restarts at zero.
        fifo_pop_i = 1'b1;
        r0 = n_reads;
        load_cmd(16'h0300, 128);
        issue_start(16'h0300, 8'd64, 8'd64);
        wait_reads(r0 + 10, 100);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outs", outs(), 0);
        tick(2);
        rst = 1'b0;
        fifo_pop_i = 1'b0;
        r0 = n_reads;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("post_reset_outs", outs(), 0);
        end
        check("post_reset_reads", n_reads - r0, 0);
        load_cmd(16'h0800, 128);
        issue_start(16'h0800, 8'd64, 8'd64);
        wait_reads(r0 + 64, 200);
        tick(20);
        check("fresh_occ_stall", n_reads - r0, 64);
        rst = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
